// File: rtl/arm_pkg.sv
// Shared ARM core definitions: datapath widths, the canonical NOP and the
// prefetch queue entry layout used by the fetch stage.
package arm_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   // MOV R0,R0 -- harmless filler presented to decode when nothing is queued
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A0_0000;

   // One queued fetch: address of the instruction plus 4, and the word itself
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Sequential fetch address; wraps modulo 2^ADDR_W by construction
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] addr);
      return addr + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory fetch bus: single-cycle request/ready handshake with
// read data valid in the accepting cycle.
interface if_prefetch_stage_if;

   logic                       imem_req;
   logic [arm_pkg::ADDR_W-1:0]  imem_addr;
   logic                       imem_ready;
   logic [arm_pkg::INSTR_W-1:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head word is read combinationally.
// Pushes into a full queue and pops from an empty one are dropped.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy tracking; reset and flush both drop every entry
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch / prefetch stage: owns the fetch PC, issues memory
// requests while the queue has room, and hands the queue head to decode.
// Optional feature macro: IF_PERF_CNT_EN adds the stall_cycles counter port.
module if_prefetch_stage
   import arm_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                branch_taken,
   input  logic [ADDR_W-1:0]   branch_addr,
   if_prefetch_stage_if.master imem,
   output logic [INSTR_W-1:0]  instruction,
   output logic [ADDR_W-1:0]   pc_out,
   output logic                instr_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]         stall_cycles
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc;
   fetch_entry_t      wr_entry;
   fetch_entry_t      head_entry;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              handshake;
   logic              fifo_push;
   logic              fifo_pop;

   // A redirect suppresses the request so nothing stale enters the queue
   assign imem.imem_req  = !rst && !branch_taken && (fifo_count < CNT_W'(DEPTH));
   assign imem.imem_addr = fetch_pc;
   assign handshake      = imem.imem_req && imem.imem_ready;
   assign fifo_push      = handshake && !fifo_full;

   assign instr_valid    = !rst && !fifo_empty;
   assign fifo_pop       = instr_valid && !freeze && !branch_taken;
   assign instruction    = instr_valid ? head_entry.instr : NOP_INSTR;
   assign pc_out         = instr_valid ? head_entry.pc    : '0;

   assign wr_entry.pc    = next_pc(fetch_pc);
   assign wr_entry.instr = imem.imem_rdata;

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (branch_taken),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (wr_entry),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Fetch PC: reset beats redirect, redirect beats sequential advance
   always_ff @(posedge clk) begin
      if (rst)               fetch_pc <= RESET_PC;
      else if (branch_taken) fetch_pc <= branch_addr;
      else if (handshake)    fetch_pc <= next_pc(fetch_pc);
   end

`ifdef IF_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   // Decode-stall counter: cycles where a valid head was held by freeze
   always_ff @(posedge clk) begin
      if (rst)                        stall_cycles <= '0;
      else if (instr_valid && freeze) stall_cycles <= sat_inc(stall_cycles);
   end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage (DEPTH=4, RESET_PC=0).
// Memory returns addr ^ 32'h5A00_0000 so each word identifies its address.
module tb_if_prefetch_stage;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        instr_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'hE1A0_0000;

   if_prefetch_stage_if bus ();

   assign bus.imem_rdata = bus.imem_addr ^ 32'h5A00_0000;

   if_prefetch_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem         (bus.master),
      .instruction  (instruction),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
      bus.imem_ready = 1'b0;
      tick(); tick();
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instruction, NOP);
      chk("rst_pc", pc_out, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("rst_stall", stall_cycles, 32'd0);
`endif

      // reset outranks a redirect presented at the same time
      branch_taken = 1'b1; branch_addr = 32'h40; bus.imem_ready = 1'b1;
      #1 chk("rst_br_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
      branch_taken = 1'b0; rst = 1'b0;
      #1;
      chk("first_addr", bus.imem_addr, 32'h0);
      chk("first_req", {31'd0, bus.imem_req}, 32'd1);
      tick();
      chk("first_valid", {31'd0, instr_valid}, 32'd1);
      chk("first_pc", pc_out, 32'h4);
      chk("first_instr", instruction, 32'h5A00_0000);

      // streaming: one per cycle, no gaps
      tick(); chk("stream_pc8", pc_out, 32'h8); chk("stream_i8", instruction, 32'h5A00_0004);
      tick(); chk("stream_pcC", pc_out, 32'hC); chk("stream_vC", {31'd0, instr_valid}, 32'd1);
      tick(); chk("stream_pc10", pc_out, 32'h10); chk("stream_i10", instruction, 32'h5A00_000C);

      // fill to full under freeze
      rst = 1'b1; tick();
      rst = 1'b0; freeze = 1'b1;
      #1 chk("fill_addr0", bus.imem_addr, 32'h0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("fill_addr", bus.imem_addr, 32'(i * 4));
         chk("fill_req", {31'd0, bus.imem_req}, 32'd1);
      end
      tick();
      chk("full_req", {31'd0, bus.imem_req}, 32'd0);
      chk("full_pc", pc_out, 32'h4);
      tick();
      chk("full_hold_req", {31'd0, bus.imem_req}, 32'd0);
      chk("full_hold_addr", bus.imem_addr, 32'h10);
      chk("full_hold_pc", pc_out, 32'h4);

      // drop to 3 entries, then redirect with freeze held
      freeze = 1'b0; bus.imem_ready = 1'b0;
      tick(); chk("pop3_pc", pc_out, 32'h8);
      freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h100; bus.imem_ready = 1'b1;
      #1 chk("br_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
      branch_taken = 1'b0;
      #1;
      chk("br_valid", {31'd0, instr_valid}, 32'd0);
      chk("br_addr", bus.imem_addr, 32'h100);
      tick();
      chk("br_pc", pc_out, 32'h104);
      chk("br_instr", instruction, 32'h5A00_0100);

      // back-pressure: ready 1,0,0,1 with freeze held
      tick(); chk("bp_addr1", bus.imem_addr, 32'h108);
      bus.imem_ready = 1'b0;
      tick(); chk("bp_addr2", bus.imem_addr, 32'h108);
      tick(); chk("bp_addr3", bus.imem_addr, 32'h108);
      bus.imem_ready = 1'b1;
      tick(); chk("bp_addr4", bus.imem_addr, 32'h10C);
      bus.imem_ready = 1'b0; freeze = 1'b0;
      #1 chk("bp_pc0", pc_out, 32'h104);
      tick(); chk("bp_pc1", pc_out, 32'h108); chk("bp_i1", instruction, 32'h5A00_0104);
      tick(); chk("bp_pc2", pc_out, 32'h10C); chk("bp_i2", instruction, 32'h5A00_0108);
      tick();
      chk("bp_empty", {31'd0, instr_valid}, 32'd0);
      chk("bp_nop", instruction, NOP);
      chk("bp_pc_zero", pc_out, 32'd0);

      // fetch address wrap
      freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      tick();
      branch_taken = 1'b0; bus.imem_ready = 1'b1;
      #1 chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr1", bus.imem_addr, 32'h0);
      chk("wrap_pc", pc_out, 32'h0);
      chk("wrap_instr", instruction, 32'hA5FF_FFFC);

      // mid-operation reset discards the queue
      rst = 1'b1;
      #1 chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      tick();
      rst = 1'b0; bus.imem_ready = 1'b0; freeze = 1'b0;
      #1;
      chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("post_rst_addr", bus.imem_addr, 32'h0);

`ifdef IF_PERF_CNT_EN
      chk("cnt_clear", stall_cycles, 32'd0);
      freeze = 1'b1; bus.imem_ready = 1'b1;
      tick(); chk("cnt_0", stall_cycles, 32'd0);
      repeat (5) tick();
      chk("cnt_5", stall_cycles, 32'd5);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the prefetch queue depth in instructions (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port freeze  input  1  hazard stall from decode; the head instruction is held.
REQ-006 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-007 SHALL have port branch_addr  input  32  redirect target, word-aligned.
REQ-008 SHALL have port imem_req  output  1  fetch request valid.
REQ-009 SHALL have port imem_addr  output  32  fetch address.
REQ-010 SHALL have port imem_ready  input  1  memory accepts the request, with data valid in the same cycle.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-012 SHALL have port instruction  output  32  head instruction to decode.
REQ-013 SHALL have port pc_out  output  32  address of the head instruction plus 4.
REQ-014 SHALL have port instr_valid  output  1  instruction/pc_out are meaningful.

Function
REQ-015 SHALL hold a fetch PC register; on a handshake (imem_req && imem_ready), it SHALL push {fetch_pc+4, imem_rdata} and advance fetch_pc by 4, wrapping modulo 2^32.
REQ-016 SHALL drive imem_req = !branch_taken && (count < DEPTH); imem_addr = fetch_pc.
REQ-017 SHALL present the queue head combinationally: instr_valid = (count != 0); when empty, instruction = NOP_INSTR and pc_out = 0.
REQ-018 SHALL pop the head when instr_valid && !freeze.
REQ-019 SHALL deliver an instruction accepted in cycle t at the outputs no earlier than cycle t+1.
REQ-020 SHALL, on a simultaneous push and pop, leave count unchanged and preserve order.
REQ-021 SHALL ignore imem_ready while imem_req is low, and SHALL never overflow or underflow the queue.
REQ-022 SHALL, when branch_taken is high, empty the queue, set fetch_pc to branch_addr, and push nothing that cycle; branch_taken SHALL take priority over freeze and over any handshake.
REQ-023 SHALL issue the first request to branch_addr in the cycle after branch_taken.
REQ-024 SHALL, while freeze is held with the queue full, keep imem_req low and all state unchanged.

Reset
REQ-025 SHALL, while rst is high, set fetch_pc = RESET_PC, count = 0, and pointers = 0; imem_req = 0; instr_valid = 0; instruction = NOP_INSTR; pc_out = 0.
REQ-026 SHALL give rst priority over branch_taken, freeze and handshakes, and any reset asserted mid-operation SHALL discard all queued instructions.

Configuration
REQ-027 SHALL, with IF_PERF_CNT_EN defined, add output stall_cycles (32), which increments every cycle instr_valid && freeze is true, saturates at all-ones, and resets to 0.
REQ-028 SHALL, without IF_PERF_CNT_EN, have no stall_cycles port and no counter logic, with all other behaviour identical.

Structure
REQ-029 SHALL take INSTR_W (32), ADDR_W (32) and NOP_INSTR (32'hE1A0_0000, which is MOV R0,R0) from the shared package arm_pkg.
REQ-030 SHALL implement the queue as one sub-module, sync_fifo, parameterised by width and DEPTH, with flush, push, pop, full, empty and count ports; the PC and request logic SHALL live in if_prefetch_stage.

Verification
REQ-031 SHALL verify reset and first fetch: release rst with imem_ready=1 -> imem_addr=0 in the first cycle; next cycle, instr_valid=1 and pc_out=4.
REQ-032 SHALL verify fill-to-full: hold freeze=1 and imem_ready=1 with DEPTH=4 -> exactly 4 handshakes (addresses 0,4,8,C); then imem_req=0, and the head stays at pc_out=4.
REQ-033 SHALL verify streaming: freeze=0, imem_ready=1 -> one instruction per cycle, pc_out=4,8,C,... with no gaps and count stable.
REQ-034 SHALL verify branch with simultaneous freeze: queue holds 3 entries, assert branch_taken=1, freeze=1, branch_addr=0x100 -> next cycle instr_valid=0 and imem_addr=0x100; one cycle later, pc_out=0x104.
REQ-035 SHALL verify memory back-pressure: toggle imem_ready 1,0,0,1 -> only two pushes, fetch_pc advances by 8, and order is preserved.
REQ-036 SHALL verify wrap and the counter: set branch_addr=0xFFFF_FFFC -> next fetch address is 0; with IF_PERF_CNT_EN, 5 frozen valid cycles give stall_cycles=5.
